sram_access_arbiter: RTL and testbench

//  Shares the single external SRAM chip between the MCU core and the JTAG debug

---
 rtl/sram_access_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_access_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Shares one external SRAM between the MCU core and the JTAG debug port, one access at a time.
// Optional build macro SRAM_ARB_DBG_SHARE_EN: debug may contend with the core while running (round-robin).
module sram_access_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              paused,
  input  logic              core_req,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_wr,
  output logic              sram_en
);

  // state  | meaning
  // IDLE   | bus free; requests sampled, winner latched on grant
  // ACCESS | sram_en held for ACCESS_CYCLES cycles
  // DONE   | rdata and ack presented to the winner for one cycle
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  localparam logic [3:0] lastCnt = 4'(ACCESS_CYCLES - 1);

  stateT      state, stateNext;
  logic [3:0] accessCnt;
  logic       coreElig, dbgElig, grantDbg, grant, lastAccess, winnerDbg;

`ifdef SRAM_ARB_DBG_SHARE_EN
  logic rrPtr;  // 0 = core wins the next tie, 1 = debug

  always_comb begin
    coreElig = core_req & ~paused;
    dbgElig  = dbg_req;
    grantDbg = dbgElig & (~coreElig | rrPtr);
  end

  always_ff @(posedge clk) begin
    if (rst)
      rrPtr <= 1'b0;
    else if (grant)
      rrPtr <= ~grantDbg;
  end
`else
  always_comb begin
    coreElig = core_req & ~paused;
    dbgElig  = dbg_req & paused;
    grantDbg = dbgElig;
  end
`endif

  assign lastAccess = (accessCnt == lastCnt);

  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (coreElig | dbgElig) begin
          grant     = 1'b1;
          stateNext = ACCESS;
        end
      end
      ACCESS:  if (lastAccess) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accessCnt  <= '0;
      winnerDbg  <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_en    <= 1'b0;
      sram_wr    <= 1'b0;
      sram_oe    <= 1'b0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
      core_ack   <= 1'b0;
      dbg_ack    <= 1'b0;
    end else begin
      core_ack <= 1'b0;
      dbg_ack  <= 1'b0;
      if (grant) begin
        winnerDbg  <= grantDbg;
        sram_addr  <= grantDbg ? dbg_addr  : core_addr;
        sram_wdata <= grantDbg ? dbg_wdata : core_wdata;
        sram_wr    <= grantDbg ? dbg_wr    : core_wr;
        sram_oe    <= grantDbg ? dbg_wr    : core_wr;
        sram_en    <= 1'b1;
        accessCnt  <= '0;
      end else if (state == ACCESS) begin
        if (lastAccess) begin
          // Address/wdata are left on the pins; only the strobes drop.
          sram_en   <= 1'b0;
          sram_wr   <= 1'b0;
          sram_oe   <= 1'b0;
          accessCnt <= '0;
          if (!sram_wr) begin
            if (winnerDbg) dbg_rdata  <= sram_rdata;
            else           core_rdata <= sram_rdata;
          end
          if (winnerDbg) dbg_ack  <= 1'b1;
          else           core_ack <= 1'b1;
        end else begin
          accessCnt <= accessCnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: directed cases plus randomized traffic
// against a transaction-timing model.
module tb_sram_access_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int AC = 2;
`ifdef SRAM_ARB_DBG_SHARE_EN
  localparam bit SHARE = 1'b1;
`else
  localparam bit SHARE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          paused = 1'b0;
  logic          core_req = 1'b0, core_wr = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic [DW-1:0] core_rdata;
  logic          core_ack;
  logic          dbg_req = 1'b0, dbg_wr = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_oe, sram_wr, sram_en;
  logic [DW-1:0] sram_rdata = '0;

  always #5 clk = ~clk;

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .paused(paused),
    .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_oe(sram_oe),
    .sram_rdata(sram_rdata), .sram_wr(sram_wr), .sram_en(sram_en)
  );

  int tests = 0;
  int fails = 0;

  task automatic checkB(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkW(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a grant in cycle g means strobes in g+1..g+AC,
  // capture at g+AC, ack in g+AC+1, bus free again at g+AC+2.
  bit            armed = 1'b0;
  int            cyc = 0;
  bit            mBusy, mDbg, mWr, mRr;
  int            mGrant;
  logic [AW-1:0] mSramAddr;
  logic [DW-1:0] mSramWdata, mCoreRd, mDbgRd;

  always @(negedge clk) begin
    bit expEn, cE, dE;
    if (armed) begin
      expEn = mBusy && (cyc <= mGrant + AC);
      checkB("sram_en", sram_en, expEn);
      checkB("sram_wr", sram_wr, expEn && mWr);
      checkB("sram_oe", sram_oe, expEn && mWr);
      checkW("sram_addr", sram_addr, mSramAddr);
      checkW("sram_wdata", sram_wdata, mSramWdata);
      checkB("core_ack", core_ack, mBusy && (cyc == mGrant + AC + 1) && !mDbg);
      checkB("dbg_ack", dbg_ack, mBusy && (cyc == mGrant + AC + 1) && mDbg);
      checkW("core_rdata", core_rdata, mCoreRd);
      checkW("dbg_rdata", dbg_rdata, mDbgRd);
    end
    if (rst) begin
      armed = 1'b1;
      mBusy = 1'b0; mRr = 1'b0;
      mSramAddr = '0; mSramWdata = '0; mCoreRd = '0; mDbgRd = '0;
    end else if (armed) begin
      if (mBusy) begin
        if (cyc == mGrant + AC && !mWr) begin
          if (mDbg) mDbgRd = sram_rdata;
          else      mCoreRd = sram_rdata;
        end
        if (cyc == mGrant + AC + 1) mBusy = 1'b0;
      end else begin
        cE = core_req && !paused;
        dE = dbg_req && (paused || SHARE);
        if (cE || dE) begin
          mDbg       = dE && (!cE || mRr);
          mBusy      = 1'b1;
          mGrant     = cyc;
          mWr        = mDbg ? dbg_wr : core_wr;
          mSramAddr  = mDbg ? dbg_addr : core_addr;
          mSramWdata = mDbg ? dbg_wdata : core_wdata;
          mRr        = !mDbg;
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic newCore();
    core_req   = 1'b1;
    core_wr    = 1'($urandom_range(0, 1));
    core_addr  = AW'($urandom);
    core_wdata = DW'($urandom);
  endtask

  task automatic newDbg();
    dbg_req   = 1'b1;
    dbg_wr    = 1'($urandom_range(0, 1));
    dbg_addr  = AW'($urandom);
    dbg_wdata = DW'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checkB("reset sram_en", sram_en, 1'b0);
    checkB("reset core_ack", core_ack, 1'b0);
    checkW("reset core_rdata", core_rdata, 16'h0000);

    // core read 0x0040 -> 0xBEEF three cycles after grant
    sram_rdata = 16'hBEEF; paused = 1'b0;
    core_wr = 1'b0; core_addr = 16'h0040; core_req = 1'b1;
    step(); checkB("t1 en N+1", sram_en, 1'b1); checkW("t1 addr", sram_addr, 16'h0040);
    step(); checkB("t1 en N+2", sram_en, 1'b1);
    step(); checkB("t1 ack N+3", core_ack, 1'b1); checkW("t1 rdata", core_rdata, 16'hBEEF);
    core_req = 1'b0;
    step(); checkB("t1 idle en", sram_en, 1'b0); checkB("t1 ack gone", core_ack, 1'b0);

    // paused debug write
    paused = 1'b1; dbg_wr = 1'b1; dbg_addr = 16'h00FF; dbg_wdata = 16'h1234; dbg_req = 1'b1;
    step(); checkB("t2 oe", sram_oe, 1'b1); checkB("t2 wr", sram_wr, 1'b1);
    checkW("t2 addr", sram_addr, 16'h00FF); checkW("t2 wdata", sram_wdata, 16'h1234);
    step(); checkB("t2 en N+2", sram_en, 1'b1);
    step(); checkB("t2 dbg_ack", dbg_ack, 1'b1); checkB("t2 core_ack", core_ack, 1'b0);
    dbg_req = 1'b0;
    step(); checkB("t2 dbg_ack gone", dbg_ack, 1'b0);

    // core blocked while paused, starts once unpaused
    core_wr = 1'b0; core_addr = 16'h0123; sram_rdata = 16'h5A5A; core_req = 1'b1;
    repeat (4) begin step(); checkB("t3 blocked en", sram_en, 1'b0); end
    paused = 1'b0;
    step(); checkB("t3 en", sram_en, 1'b1);
    step();
    step(); checkB("t3 ack", core_ack, 1'b1); checkW("t3 rdata", core_rdata, 16'h5A5A);
    core_req = 1'b0;
    step();

    // reset during the second access cycle aborts without ack
    core_addr = 16'h0077; sram_rdata = 16'h0F0F; core_req = 1'b1;
    step(); checkB("t4 en", sram_en, 1'b1);
    step(); rst = 1'b1;
    step(); checkB("t4 rst en", sram_en, 1'b0); checkB("t4 rst ack", core_ack, 1'b0);
    checkW("t4 rst addr", sram_addr, 16'h0000); checkW("t4 rst rdata", core_rdata, 16'h0000);
    rst = 1'b0;
    step(); checkB("t4 restart en", sram_en, 1'b1);
    step(); checkB("t4 restart en2", sram_en, 1'b1);
    step(); checkB("t4 ack", core_ack, 1'b1); checkW("t4 rdata", core_rdata, 16'h0F0F);
    core_req = 1'b0;
    step();

    // back-to-back reads, one idle cycle between
    core_addr = 16'h0001; sram_rdata = 16'h1111; core_req = 1'b1;
    step(); step();
    step(); checkB("t5 ack1", core_ack, 1'b1); checkW("t5 rdata1", core_rdata, 16'h1111);
    core_addr = 16'h0002; sram_rdata = 16'h2222;
    step(); checkB("t5 gap", sram_en, 1'b0);
    step(); checkB("t5 en2", sram_en, 1'b1); checkW("t5 addr2", sram_addr, 16'h0002);
    step();
    step(); checkB("t5 ack2", core_ack, 1'b1); checkW("t5 rdata2", core_rdata, 16'h2222);
    core_req = 1'b0;
    step();

`ifdef SRAM_ARB_DBG_SHARE_EN
    rst = 1'b1; step(); rst = 1'b0;
    paused = 1'b0; core_wr = 1'b0; dbg_wr = 1'b0; core_req = 1'b1; dbg_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      do begin step(); n++; end while (!(core_ack || dbg_ack) && n < 20);
      checkB("rr winner", dbg_ack, 1'(k % 2));
      if (k > 0) checkW("rr spacing", 16'(n), 16'(AC + 2));
    end
    core_req = 1'b0; dbg_req = 1'b0;
    step(); step();
`endif

    for (int i = 0; i < 3000; i++) begin
      step();
      sram_rdata = DW'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) paused = !paused;
      if (core_ack) begin
        if ($urandom_range(0, 1) == 0) core_req = 1'b0; else newCore();
      end else if (!core_req) begin
        if ($urandom_range(0, 3) == 0) newCore();
      end else if ($urandom_range(0, 31) == 0) begin
        core_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        core_addr = AW'($urandom); core_wdata = DW'($urandom);
      end
      if (dbg_ack) begin
        if ($urandom_range(0, 1) == 0) dbg_req = 1'b0; else newDbg();
      end else if (!dbg_req) begin
        if ($urandom_range(0, 3) == 0) newDbg();
      end else if ($urandom_range(0, 31) == 0) begin
        dbg_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        dbg_addr = AW'($urandom); dbg_wdata = DW'($urandom);
      end
    end
    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
